// File: rtl/ddr_arb_pkg.sv
// Shared types and helpers for the two-requester DDR3 write-channel arbiter.
package ddr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  localparam int unsigned BEAT_CNT_W = 4;
  localparam int unsigned ID_MAX_W   = 32;

  // Requester index zero-extended; callers size-cast down to their ID width.
  function automatic logic [ID_MAX_W-1:0] idx_to_id(input logic index);
    return {{(ID_MAX_W-1){1'b0}}, index};
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: the pointer breaks ties, a lone request always wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       valid,
  output logic       idx
);

  always_comb begin
    valid = |req;
    idx   = (req == 2'b11) ? ptr : req[1];
  end

endmodule

// File: rtl/ddr_wr_arbiter.sv
// Burst-granular round-robin arbiter sharing one DDR3 AXI write channel between
// two frame writers, with a sticky check of the controller's last-beat flag.
module ddr_wr_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    rstn,

  input  logic                    m0_awvalid,
  input  logic [ADDR_WIDTH-1:0]   m0_awaddr,
  input  logic [3:0]              m0_awlen,
  output logic                    m0_awready,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
  output logic                    m0_wready,
  output logic                    m0_wlast,

  input  logic                    m1_awvalid,
  input  logic [ADDR_WIDTH-1:0]   m1_awaddr,
  input  logic [3:0]              m1_awlen,
  output logic                    m1_awready,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
  output logic                    m1_wready,
  output logic                    m1_wlast,

  output logic [ADDR_WIDTH-1:0]   axi_awaddr,
  output logic [ID_WIDTH-1:0]     axi_awuser_id,
  output logic [3:0]              axi_awlen,
  output logic                    axi_awvalid,
  input  logic                    axi_awready,
  output logic [DATA_WIDTH-1:0]   axi_wdata,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                    axi_wready,
  input  logic                    axi_wusero_last,

  output logic                    grant,
  output logic                    busy,
  output logic                    err_last
);

  arb_state_t            state, state_nxt;
  logic                  ptr;
  logic [BEAT_CNT_W-1:0] beat_cnt;
  logic                  pick_valid, pick_idx;
  logic                  in_addr, in_data, aw_hs, beat, final_beat;

  rr_pick2 u_pick (
    .req   ({m1_awvalid, m0_awvalid}),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    in_addr    = (state == ADDR);
    in_data    = (state == DATA);
    aw_hs      = in_addr & axi_awready;
    beat       = in_data & axi_wready;
    final_beat = beat & (beat_cnt == '0);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid)  state_nxt = ADDR;
      ADDR:    if (axi_awready) state_nxt = DATA;
      DATA:    if (final_beat)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr           <= 1'b0;
      grant         <= 1'b0;
      axi_awaddr    <= '0;
      axi_awlen     <= '0;
      axi_awuser_id <= '0;
      axi_awvalid   <= 1'b0;
      beat_cnt      <= '0;
      err_last      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant         <= pick_idx;
            axi_awaddr    <= pick_idx ? m1_awaddr : m0_awaddr;
            axi_awlen     <= pick_idx ? m1_awlen  : m0_awlen;
            axi_awuser_id <= ID_WIDTH'(idx_to_id(pick_idx));
            axi_awvalid   <= 1'b1;
          end
        end
        ADDR: begin
          if (axi_awready) begin
            axi_awvalid <= 1'b0;
            beat_cnt    <= axi_awlen;
          end
        end
        DATA: begin
          if (axi_wready) begin
            if (beat_cnt == '0) ptr      <= ~grant;
            else                beat_cnt <= beat_cnt - 1'b1;
          end
        end
        default: ;
      endcase
      // Flag must be high on the counted final beat and low on every other beat.
      if (beat && (axi_wusero_last != (beat_cnt == '0)))
        err_last <= 1'b1;
    end
  end

  always_comb begin
    busy       = (state != IDLE);
    m0_awready = aw_hs & ~grant;
    m1_awready = aw_hs &  grant;
    m0_wready  = beat & ~grant;
    m1_wready  = beat &  grant;
    m0_wlast   = in_data & axi_wusero_last & ~grant;
    m1_wlast   = in_data & axi_wusero_last &  grant;
    axi_wdata  = '0;
    axi_wstrb  = '0;
    if (in_data) begin
      axi_wdata = grant ? m1_wdata : m0_wdata;
      axi_wstrb = grant ? m1_wstrb : m0_wstrb;
    end
  end

endmodule

// File: tb/tb_ddr_wr_arbiter.sv
// Self-checking bench for ddr_wr_arbiter: a table-driven single burst, directed
// corner sequences, and randomized traffic against a transaction-level model.
module tb_ddr_wr_arbiter;

  localparam int AW = 28;
  localparam int DW = 256;
  localparam int IW = 4;
  localparam int SW = DW / 8;

  logic          clk  = 1'b0;
  logic          rstn = 1'b1;
  logic          m0_awvalid = 1'b0, m1_awvalid = 1'b0;
  logic [AW-1:0] m0_awaddr = '0, m1_awaddr = '0;
  logic [3:0]    m0_awlen = '0, m1_awlen = '0;
  logic          m0_awready, m1_awready;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic [SW-1:0] m0_wstrb = '0, m1_wstrb = '0;
  logic          m0_wready, m1_wready, m0_wlast, m1_wlast;
  logic [AW-1:0] axi_awaddr;
  logic [IW-1:0] axi_awuser_id;
  logic [3:0]    axi_awlen;
  logic          axi_awvalid;
  logic          axi_awready = 1'b0;
  logic [DW-1:0] axi_wdata;
  logic [SW-1:0] axi_wstrb;
  logic          axi_wready = 1'b0, axi_wusero_last = 1'b0;
  logic          grant, busy, err_last;

  always #5 clk = ~clk;

  ddr_wr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rstn(rstn),
    .m0_awvalid(m0_awvalid), .m0_awaddr(m0_awaddr), .m0_awlen(m0_awlen), .m0_awready(m0_awready),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wready(m0_wready), .m0_wlast(m0_wlast),
    .m1_awvalid(m1_awvalid), .m1_awaddr(m1_awaddr), .m1_awlen(m1_awlen), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wready(m1_wready), .m1_wlast(m1_wlast),
    .axi_awaddr(axi_awaddr), .axi_awuser_id(axi_awuser_id), .axi_awlen(axi_awlen),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_wdata(axi_wdata),
    .axi_wstrb(axi_wstrb), .axi_wready(axi_wready), .axi_wusero_last(axi_wusero_last),
    .grant(grant), .busy(busy), .err_last(err_last)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level reference: one burst in flight, remaining beats as an integer.
  bit            mb_busy, mb_addr, m_grant, m_ptr, m_err;
  int            m_left, m_beats, bursts_done;
  logic [AW-1:0] m_addr;
  logic [3:0]    m_len;
  bit            grant_log[$];
  int            beat_log[$];
  int            dut_beats, addr_hold;

  bit            pend[2];
  logic [AW-1:0] paddr[2];
  logic [3:0]    plen[2];

  bit manual, rand_ctrl, auto_rand, auto_cont;
  int aw_delay, aw_wait, wcyc, bad_beat;
  bit wpat[4];

  typedef struct {
    bit m0v, m1v, awr, wr, wl;
    bit e_awvalid, e_m0_awready, e_m0_wready, e_m0_wlast, e_m1_wready, e_busy;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(string nm, logic act, logic exp);
    chk(nm, DW'(act), DW'(exp));
  endtask

  function automatic bit pick(bit r0, bit r1, bit p);
    if (r0 && r1) return p;
    return r1;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic model_reset();
    mb_busy = 0; mb_addr = 0; m_grant = 0; m_ptr = 0; m_err = 0;
    m_left = 0; m_beats = 0; aw_wait = 0; wcyc = 0;
    pend[0] = 0; pend[1] = 0;
  endtask

  task automatic check_model();
    bit dph;
    dph = mb_busy && !mb_addr;
    chk1("axi_awvalid", axi_awvalid, mb_addr);
    chk1("busy", busy, mb_busy);
    chk1("grant", grant, m_grant);
    chk1("err_last", err_last, m_err);
    if (mb_addr) begin
      chk("axi_awaddr", DW'(axi_awaddr), DW'(m_addr));
      chk("axi_awlen", DW'(axi_awlen), DW'(m_len));
      chk("axi_awuser_id", DW'(axi_awuser_id), DW'(m_grant));
    end
    chk1("m0_awready", m0_awready, mb_addr && axi_awready && !m_grant);
    chk1("m1_awready", m1_awready, mb_addr && axi_awready && m_grant);
    chk1("m0_wready", m0_wready, dph && axi_wready && !m_grant);
    chk1("m1_wready", m1_wready, dph && axi_wready && m_grant);
    chk1("m0_wlast", m0_wlast, dph && axi_wusero_last && !m_grant);
    chk1("m1_wlast", m1_wlast, dph && axi_wusero_last && m_grant);
    chk("axi_wdata", axi_wdata, dph ? (m_grant ? m1_wdata : m0_wdata) : '0);
    chk("axi_wstrb", DW'(axi_wstrb), dph ? DW'(m_grant ? m1_wstrb : m0_wstrb) : '0);
    if (m0_wready || m1_wready) dut_beats++;
    if (axi_awvalid && !axi_awready) addr_hold++;
  endtask

  task automatic model_update();
    bit w;
    if (mb_addr && axi_awready) pend[m_grant] = 0;
    if (!mb_busy) begin
      if (m0_awvalid || m1_awvalid) begin
        w = pick(m0_awvalid, m1_awvalid, m_ptr);
        m_grant = w;
        m_addr  = w ? m1_awaddr : m0_awaddr;
        m_len   = w ? m1_awlen : m0_awlen;
        mb_busy = 1; mb_addr = 1; dut_beats = 0;
        grant_log.push_back(w);
      end
    end else if (mb_addr) begin
      if (axi_awready) begin
        mb_addr = 0; m_left = int'(m_len) + 1; m_beats = 0;
      end
    end else if (axi_wready) begin
      if (axi_wusero_last != (m_left == 1)) m_err = 1;
      m_left--; m_beats++;
      if (m_left == 0) begin
        mb_busy = 0; m_ptr = !m_grant; bursts_done++;
        beat_log.push_back(dut_beats);
      end
    end
  endtask

  task automatic drive();
    bit dph;
    m0_wdata = rnd_data(); m1_wdata = rnd_data();
    m0_wstrb = $urandom;   m1_wstrb = $urandom;
    if (manual) return;
    for (int m = 0; m < 2; m++) begin
      if (auto_cont && !pend[m]) begin
        pend[m] = 1; plen[m] = 4'hF; paddr[m] = AW'($urandom);
      end
      if (auto_rand && !pend[m] && $urandom_range(3) == 0) begin
        pend[m] = 1; plen[m] = 4'($urandom_range(15)); paddr[m] = AW'($urandom);
      end
    end
    m0_awvalid = pend[0]; m0_awaddr = paddr[0]; m0_awlen = plen[0];
    m1_awvalid = pend[1]; m1_awaddr = paddr[1]; m1_awlen = plen[1];
    dph = mb_busy && !mb_addr;
    if (rand_ctrl) begin
      axi_awready = 1'($urandom_range(1));
      axi_wready  = 1'($urandom_range(1));
    end else begin
      axi_awready = mb_addr && (aw_wait > aw_delay);
      axi_wready  = dph && wpat[wcyc % 4];
    end
    axi_wusero_last = dph && axi_wready && ((m_left == 1) || (m_beats + 1 == bad_beat));
    if (rand_ctrl && !dph) axi_wusero_last = 1'($urandom_range(1));
  endtask

  task automatic step();
    bit was_dph;
    @(negedge clk);
    check_model();
    @(posedge clk);
    was_dph = mb_busy && !mb_addr;
    model_update();
    aw_wait = mb_addr ? aw_wait + 1 : 0;
    if (mb_busy && !mb_addr) wcyc = was_dph ? wcyc + 1 : 0;
    #1;
    drive();
  endtask

  task automatic request(int m, logic [AW-1:0] a, logic [3:0] l);
    pend[m] = 1; paddr[m] = a; plen[m] = l;
    drive();
  endtask

  task automatic run_bursts(int n, int budget);
    int target = bursts_done + n;
    int c = 0;
    while (bursts_done < target && c < budget) begin step(); c++; end
    chk("bursts_done", DW'(bursts_done), DW'(target));
  endtask

  task automatic wait_grant(int budget);
    int c = 0;
    while (!mb_addr && c < budget) begin step(); c++; end
    chk1("grant_seen", axi_awvalid, 1'b1);
  endtask

  task automatic drain(int budget);
    int c = 0;
    while ((mb_busy || pend[0] || pend[1]) && c < budget) begin step(); c++; end
    chk1("drained_busy", busy, 1'b0);
  endtask

  task automatic do_reset(bit check);
    #2 rstn = 1'b0;
    #1;
    if (check) begin
      chk1("rst_awvalid", axi_awvalid, 1'b0);
      chk("rst_awaddr", DW'(axi_awaddr), '0);
      chk("rst_awlen", DW'(axi_awlen), '0);
      chk("rst_awuser_id", DW'(axi_awuser_id), '0);
      chk1("rst_grant", grant, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_err_last", err_last, 1'b0);
      chk("rst_ready_last", DW'({m0_awready, m1_awready, m0_wready, m1_wready, m0_wlast, m1_wlast}), '0);
      chk("rst_wdata", axi_wdata, '0);
    end
    model_reset();
    m0_awvalid = 0; m1_awvalid = 0;
    axi_awready = 0; axi_wready = 0; axi_wusero_last = 0;
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    drive();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, b0;
    wpat = '{1, 1, 1, 1};
    aw_delay = 0; bad_beat = 0;
    manual = 1; rand_ctrl = 0; auto_rand = 0; auto_cont = 0;
    do_reset(1);

    // Single m0 burst, addr 0x100, awlen=3, stimulus and expectations per cycle.
    //           m0v m1v awr wr wl | awv m0awr m0wr m0wl m1wr busy
    vecs[0] = '{1, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0};
    vecs[1] = '{1, 0, 0, 1, 0,  1, 0, 0, 0, 0, 1};
    vecs[2] = '{1, 0, 1, 0, 0,  1, 1, 0, 0, 0, 1};
    vecs[3] = '{0, 0, 0, 1, 0,  0, 0, 1, 0, 0, 1};
    vecs[4] = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1};
    vecs[5] = '{0, 0, 0, 1, 0,  0, 0, 1, 0, 0, 1};
    vecs[6] = '{0, 0, 0, 1, 0,  0, 0, 1, 0, 0, 1};
    vecs[7] = '{0, 0, 0, 1, 1,  0, 0, 1, 1, 0, 1};
    vecs[8] = '{0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0};
    m0_awaddr = AW'(28'h0000100); m0_awlen = 4'd3;
    for (int i = 0; i < 9; i++) begin
      m0_awvalid = vecs[i].m0v; m1_awvalid = vecs[i].m1v;
      axi_awready = vecs[i].awr; axi_wready = vecs[i].wr; axi_wusero_last = vecs[i].wl;
      @(negedge clk);
      check_model();
      chk1("t_awvalid", axi_awvalid, vecs[i].e_awvalid);
      chk1("t_m0_awready", m0_awready, vecs[i].e_m0_awready);
      chk1("t_m0_wready", m0_wready, vecs[i].e_m0_wready);
      chk1("t_m0_wlast", m0_wlast, vecs[i].e_m0_wlast);
      chk1("t_m1_wready", m1_wready, vecs[i].e_m1_wready);
      chk1("t_busy", busy, vecs[i].e_busy);
      if (vecs[i].e_awvalid) begin
        chk("t_awaddr", DW'(axi_awaddr), DW'(28'h0000100));
        chk("t_awuser_id", DW'(axi_awuser_id), '0);
      end
      @(posedge clk);
      model_update();
      #1;
      drive();
    end
    chk("t_beats", DW'(beat_log[beat_log.size()-1]), DW'(4));
    manual = 0;

    // Pointer now favours m1: both request, m1 must win.
    g0 = grant_log.size();
    request(0, AW'(28'h0123450), 4'd2);
    request(1, AW'(28'h0ABCDE0), 4'd3);
    wait_grant(5);
    chk("p1_awaddr", DW'(axi_awaddr), DW'(28'h0ABCDE0));
    chk("p1_awuser_id", DW'(axi_awuser_id), DW'(1));
    run_bursts(2, 60);
    chk1("p1_first", grant_log[g0], 1'b1);
    chk1("p1_second", grant_log[g0+1], 1'b0);

    // Continuous requests from both, 16-beat bursts.
    g0 = grant_log.size(); b0 = beat_log.size();
    auto_cont = 1; drive();
    run_bursts(4, 200);
    auto_cont = 0;
    drain(200);
    chk1("rr_first", grant_log[g0], 1'b1);
    for (int k = 1; k < 4; k++) chk1("rr_alternate", grant_log[g0+k], !grant_log[g0+k-1]);
    for (int k = 0; k < 4; k++) chk("rr_beats", DW'(beat_log[b0+k]), DW'(16));

    // Controller stalls; requester scribbles its address after the grant.
    aw_delay = 5; wpat = '{1, 0, 0, 1};
    request(0, AW'(28'h0200000), 4'd1);
    wait_grant(5);
    addr_hold = 0;
    paddr[0] = AW'(28'hFFFFFFF); plen[0] = 4'hF; drive();
    run_bursts(1, 40);
    chk("stall_addr_hold", DW'(addr_hold), DW'(5));
    chk("stall_beats", DW'(beat_log[beat_log.size()-1]), DW'(2));

    // Early last-beat flag on beat 2 of a 4-beat burst.
    aw_delay = 0; wpat = '{1, 1, 1, 1}; bad_beat = 2;
    request(1, AW'(28'h0000400), 4'd3);
    run_bursts(1, 20);
    bad_beat = 0;
    chk1("mm_err", err_last, 1'b1);
    chk("mm_beats", DW'(beat_log[beat_log.size()-1]), DW'(4));
    repeat (3) step();
    chk1("mm_err_sticky", err_last, 1'b1);

    // Reset after 3 beats of an 8-beat m0 burst.
    request(0, AW'(28'h0300000), 4'd7);
    begin
      int c = 0;
      while (!(mb_busy && !mb_addr && m_beats == 3) && c < 30) begin step(); c++; end
    end
    chk1("pre_reset_busy", busy, 1'b1);
    do_reset(1);
    repeat (3) step();
    chk1("post_reset_err", err_last, 1'b0);
    chk1("post_reset_busy", busy, 1'b0);

    // Randomized traffic and controller behaviour.
    rand_ctrl = 1; auto_rand = 1; drive();
    repeat (1500) step();
    auto_rand = 0;
    drain(600);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_wr_arbiter.md
Name: ddr_wr_arbiter

Overview:
- Shares the single DDR3 AXI write channel (address + data) between two burst-write requesters, typically cam1 and cam2 frame writers.
- Arbitration is round-robin at burst granularity; once granted, a burst runs to completion without preemption.
- Sits between the per-camera frame writers and the DDR3 controller write ports, in the DDR clock domain.
- Checks the controller's last-beat flag against its own beat count and latches a sticky error on mismatch.

Parameters:
ADDR_WIDTH, 28, AXI address width (row 15 + bank 3 + column 10)
DATA_WIDTH, 256, AXI write data width (MEM_DQ_WIDTH*8)
ID_WIDTH, 4, awuser_id width; requester index is zero-extended into it

Ports:
clk  in  1  DDR controller clock (ddrphy_clkin); only clock
rstn  in  1  asynchronous active-low reset
m0_awvalid / m1_awvalid  in  1  requester burst request; held until its awready
m0_awaddr / m1_awaddr  in  ADDR_WIDTH  burst start address
m0_awlen / m1_awlen  in  4  beats minus 1
m0_awready / m1_awready  out  1  one-cycle address-accept pulse
m0_wdata / m1_wdata  in  DATA_WIDTH  write beat, valid whenever the requester is granted
m0_wstrb / m1_wstrb  in  DATA_WIDTH/8  byte strobes
m0_wready / m1_wready  out  1  beat consumed this cycle
m0_wlast / m1_wlast  out  1  controller last-beat flag, routed to the granted requester only
axi_awaddr  out  ADDR_WIDTH  to controller
axi_awuser_id  out  ID_WIDTH  granted requester index
axi_awlen  out  4  registered burst length
axi_awvalid  out  1  registered address valid
axi_awready  in  1  controller address accept
axi_wdata  out  DATA_WIDTH  combinational mux of the granted requester's wdata
axi_wstrb  out  DATA_WIDTH/8  combinational mux of the granted requester's wstrb
axi_wready  in  1  controller consumes a beat
axi_wusero_last  in  1  controller last-beat flag
grant  out  1  index of the current or last granted requester
busy  out  1  high in ADDR or DATA state
err_last  out  1  sticky: axi_wusero_last disagreed with the internal beat count

Behaviour:
- Reset values (asynchronous, rstn=0):
  - state=IDLE, priority pointer=0 (m0 preferred).
  - axi_awvalid=0, axi_awaddr=0, axi_awlen=0, axi_awuser_id=0.
  - grant=0, busy=0, err_last=0.
  - All mN_awready, mN_wready and mN_wlast = 0.
- Reset mid-burst aborts the burst with no completion signalling.
- States: IDLE -> ADDR -> DATA -> IDLE.
- IDLE:
  - Candidates are the requesters with mN_awvalid=1.
  - Both valid: the one equal to the priority pointer wins. One valid: it wins regardless of the pointer.
  - Next edge: register grant, axi_awaddr, axi_awlen and axi_awuser_id from the winner; set axi_awvalid=1; go to ADDR.
  - Latency from awvalid to axi_awvalid is 1 cycle.
- ADDR:
  - Hold axi_awvalid and the address fields stable.
  - On axi_awready=1: mG_awready=1 for exactly that cycle (combinational axi_awready & granted).
  - Next edge: axi_awvalid=0, beat counter=axi_awlen, go to DATA.
  - Address and length are latched at grant, so a requester that drops awvalid early does not corrupt the transfer.
- DATA:
  - axi_wdata/axi_wstrb select the granted requester's data.
  - mG_wready = axi_wready. mG_wlast = axi_wusero_last. The non-granted requester sees 0 on both.
  - Each cycle with axi_wready=1 decrements the counter.
  - Beat with counter==0 and axi_wready=1 (the final beat): next state IDLE, pointer = ~grant.
  - A new request is not granted in the same cycle as the final beat. At least one IDLE cycle always separates bursts.
- Last-beat check:
  - err_last is set when axi_wready & axi_wusero_last & counter!=0.
  - err_last is also set when the final beat arrives with axi_wusero_last=0.
  - err_last clears only on reset.
  - The burst still ends on the internal count.
- Counter width is 4 bits; awlen=15 gives 16 beats, and there is no wrap beyond 0.
- axi_wready asserted outside DATA is ignored and routed nowhere.
- Outside DATA, axi_wdata and axi_wstrb drive zero.
- grant holds its last value while in IDLE.

Decomposition:
- Package ddr_arb_pkg:
  - state enum {IDLE, ADDR, DATA}.
  - localparam BEAT_CNT_W=4.
  - Function idx_to_id(index) -> ID_WIDTH.
- Sub-module rr_pick2: combinational 2-way round-robin picker.
  - Inputs: req[1:0], ptr.
  - Outputs: valid, idx.

Test Plan:
- Reset during DATA (m0 burst, awlen=7, after 3 beats) -> all outputs at reset values within the same cycle; after release, state=IDLE and err_last=0.
- Only m0 requests, addr=0x0000100, awlen=3:
  - axi_awvalid rises 1 cycle after m0_awvalid, with awuser_id=0.
  - m0_awready pulses for one cycle on axi_awready.
  - Exactly 4 m0_wready pulses, with m0_wlast on the 4th.
  - m1_wready stays 0 throughout.
  - busy falls after the 4th beat.
- Both request continuously, awlen=15 -> grants alternate m0, m1, m0, m1; each burst is 16 beats; at least one IDLE cycle between bursts.
- Both request with pointer=1 after an m0 burst, m1 addr=0x0ABCDE0 -> axi_awaddr=0x0ABCDE0, awuser_id=1, and axi_wdata equals m1_wdata for every beat.
- Controller stalls: axi_awready delayed 5 cycles and axi_wready toggling 1,0,0,1 with awlen=1 -> address held stable for 5 cycles; exactly 2 beats counted; m1 unaffected.
- Controller mismatches the last-beat flag: axi_wusero_last on beat 2 of an awlen=3 burst -> err_last=1 the next cycle and stays set; the burst still completes after 4 beats.
